seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001: Parameter MAX_W, default 8, maximum pattern length in bits (2..16).
REQ-002: Parameter LEN_W, default 4, width of the pattern-length and fill fields; SHALL satisfy 2^LEN_W > MAX_W.
REQ-003: Parameter CNT_W, default 8, width of the match counter.
REQ-004: clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005: rst  input  1  reset, synchronous, active-low.
REQ-006: x  input  1  serial data bit.
REQ-007: x_valid  input  1  high = x is sampled this edge; low = hold all state except the z pulse.
REQ-008: pat  input  MAX_W  pattern; bit pat[len-1] is the first bit expected, pat[0] the last.
REQ-009: pat_len  input  LEN_W  pattern length in bits.
REQ-010: pat_load  input  1  latch pat/pat_len into internal registers.
REQ-011: overlap_en  input  1  1 = overlapping matches counted; 0 = history cleared after each match.
REQ-012: z  output  1  registered one-cycle match pulse.
REQ-013: match_cnt  output  CNT_W  saturating count of matches since reset or load.
REQ-014: fill  output  LEN_W  number of valid history bits, 0..len.
REQ-015: armed  output  1  high when fill == len (next valid bit can complete a match).

Function
REQ-016: Effective length len SHALL be pat_len clamped: 0 -> 1, values > MAX_W -> MAX_W.
REQ-017: History register hist (MAX_W bits) SHALL shift left on each valid bit: hist <= {hist[MAX_W-2:0], x}.
REQ-018: Only the low len bits of hist and of the latched pattern SHALL take part in comparison; upper bits are ignored.
REQ-019: Match condition: x_valid high, fill >= len-1 before the edge, and the low len bits of {hist[MAX_W-2:0], x} equal the latched pattern's low len bits.
REQ-020: On a match, z SHALL be 1 for exactly the one cycle following the sampling edge; otherwise z = 0.
REQ-021: fill SHALL increment by 1 per valid bit, saturating at len.
REQ-022: On a match with overlap_en = 1, hist and fill SHALL update normally (fill stays len).
REQ-023: On a match with overlap_en = 0, hist SHALL clear to 0 and fill to 0 on that edge.
REQ-024: match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1 (no wrap).
REQ-025: pat_load high SHALL latch pat and clamped len, clear hist, fill and match_cnt; any bit presented on the same edge is discarded and z = 0 next cycle.
REQ-026: Control FSM states: EMPTY (fill=0), FILLING (0<fill<len), ARMED (fill=len); armed = (state == ARMED).
REQ-027: Transitions: EMPTY->FILLING on a valid bit when len>1, EMPTY->ARMED when len=1; FILLING->ARMED when fill reaches len; ARMED->EMPTY on a non-overlap match; any state->EMPTY on pat_load.
REQ-028: overlap_en SHALL be sampled per edge; changing it mid-stream affects only subsequent matches.
REQ-029: x_valid low SHALL leave hist, fill, state and match_cnt unchanged.

Reset
REQ-030: With rst low at an edge: hist=0, fill=0, state=EMPTY, z=0, armed=0, match_cnt=0, latched pattern=0, latched len=MAX_W.
REQ-031: Reset SHALL take priority over pat_load and x_valid, including reset asserted mid-match (no z pulse follows).

Verification
REQ-032: Load pat=5'b11001, len=5, overlap_en=1; stream 1,1,0,0,1,1,0,0,1 -> z pulses after bits 5 and 9; match_cnt=2.
REQ-033: Same stream, overlap_en=0 -> z pulses after bit 5 only; fill=4 after bit 9; match_cnt=1.
REQ-034: Load pat=4'b1010, len=4; stream 1,0,1,0,1,0 -> overlap: pulses after bits 4 and 6; non-overlap: after bit 4 only.
REQ-035: CNT_W=2, pat=1'b1, len=1, five valid 1s -> z each cycle, match_cnt stops at 3; x_valid low between bits inserts no z and no state change.
REQ-036: pat_load (pat_len=0 -> len 1, and pat_len=12 with MAX_W=8 -> len 8) and rst asserted while armed -> fill=0, match_cnt=0, z=0 next cycle.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector: programmable pattern and length,
// optional overlapping matches, saturating match counter.
module seq_detect_param #(
    parameter int unsigned MAX_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic [MAX_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             pat_load,
    input  logic             overlap_en,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LEN_W-1:0] fill,
    output logic             armed
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    state_t           state;
    logic [MAX_W-1:0] hist;
    logic [MAX_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;

    logic [LEN_W-1:0] len_clamp_c;
    logic [MAX_W-1:0] cmp_mask_c;
    logic [MAX_W-1:0] shifted_c;
    logic             match_c;
    logic             clear_c;
    logic [LEN_W-1:0] fill_next_c;

    // Clamp the requested length into 1..MAX_W before it is latched
    always_comb begin
        len_clamp_c = pat_len;
        if (pat_len == '0) begin
            len_clamp_c = LEN_ONE;
        end else if (pat_len > LEN_MAX) begin
            len_clamp_c = LEN_MAX;
        end
    end

    // Match detection over the low len bits of the history including the incoming bit
    always_comb begin
        cmp_mask_c  = ~({MAX_W{1'b1}} << len_q);
        shifted_c   = {hist[MAX_W-2:0], x};
        match_c     = x_valid
                      && (fill >= (len_q - LEN_ONE))
                      && (((shifted_c ^ pat_q) & cmp_mask_c) == '0);
        clear_c     = match_c && !overlap_en;
        fill_next_c = fill;
        if (clear_c) begin
            fill_next_c = '0;
        end else if (fill < len_q) begin
            fill_next_c = fill + LEN_ONE;
        end
    end

    // Datapath, counter and control FSM; reset beats load beats data
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            hist      <= '0;
            pat_q     <= '0;
            len_q     <= LEN_MAX;
            fill      <= '0;
            match_cnt <= '0;
            z         <= 1'b0;
        end else if (pat_load) begin
            state     <= EMPTY;
            hist      <= '0;
            pat_q     <= pat;
            len_q     <= len_clamp_c;
            fill      <= '0;
            match_cnt <= '0;
            z         <= 1'b0;
        end else begin
            z <= match_c;
            if (x_valid) begin
                hist <= clear_c ? '0 : shifted_c;
                fill <= fill_next_c;
                if (match_c && (match_cnt != '1)) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
                case (state)
                    EMPTY: begin
                        if (clear_c) begin
                            state <= EMPTY;
                        end else if (len_q == LEN_ONE) begin
                            state <= ARMED;
                        end else begin
                            state <= FILLING;
                        end
                    end
                    FILLING: begin
                        if (clear_c) begin
                            state <= EMPTY;
                        end else if ((fill + LEN_ONE) == len_q) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (clear_c) begin
                            state <= EMPTY;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign armed = (state == ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (MAX_W=8, LEN_W=4, CNT_W=2).
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       x;
    logic       x_valid;
    logic [7:0] pat;
    logic [3:0] pat_len;
    logic       pat_load;
    logic       overlap_en;
    logic       z;
    logic [1:0] match_cnt;
    logic [3:0] fill;
    logic       armed;

    int checks = 0;
    int errors = 0;

    seq_detect_param #(.MAX_W(8), .LEN_W(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .x_valid    (x_valid),
        .pat        (pat),
        .pat_len    (pat_len),
        .pat_load   (pat_load),
        .overlap_en (overlap_en),
        .z          (z),
        .match_cnt  (match_cnt),
        .fill       (fill),
        .armed      (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one edge and settle away from it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b);
        x       = b;
        x_valid = 1'b1;
        cyc();
        x_valid = 1'b0;
    endtask

    task automatic idle();
        x_valid = 1'b0;
        cyc();
    endtask

    // load with a bit presented on the same edge (must be discarded)
    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic b);
        pat      = p;
        pat_len  = l;
        pat_load = 1'b1;
        x        = b;
        x_valid  = 1'b1;
        cyc();
        pat_load = 1'b0;
        x_valid  = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] bits, input int n,
                       input logic [15:0] zexp, input logic [15:0] fexp_last);
        for (int i = 0; i < n; i++) begin
            bit_in(bits[n-1-i]);
            chk($sformatf("%s_z%0d", tag, i + 1), 32'(z), 32'(zexp[n-1-i]));
        end
        chk($sformatf("%s_fill", tag), 32'(fill), 32'(fexp_last));
    endtask

    initial begin
        rst = 1'b0; x = 1'b0; x_valid = 1'b0; pat = '0; pat_len = '0;
        pat_load = 1'b0; overlap_en = 1'b1;
        cyc(); cyc();
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        rst = 1'b1;

        // reset defaults: pattern 0, len 8 -> eighth zero matches
        run("dflt", 16'b0000_0000, 8, 16'b0000_0001, 16'd8);
        chk("dflt_cnt", 32'(match_cnt), 32'd1);
        chk("dflt_armed", 32'(armed), 32'd1);

        // 11001 overlap
        overlap_en = 1'b1;
        load(8'h19, 4'd5, 1'b1);
        chk("l1_z", 32'(z), 32'd0);
        chk("l1_cnt", 32'(match_cnt), 32'd0);
        chk("l1_fill", 32'(fill), 32'd0);
        run("ov5", 16'b1_1001_1001, 9, 16'b0_0001_0001, 16'd5);
        chk("ov5_cnt", 32'(match_cnt), 32'd2);
        chk("ov5_armed", 32'(armed), 32'd1);

        // 11001 non-overlap
        overlap_en = 1'b0;
        load(8'h19, 4'd5, 1'b0);
        run("no5", 16'b1_1001_1001, 9, 16'b0_0001_0000, 16'd4);
        chk("no5_cnt", 32'(match_cnt), 32'd1);
        chk("no5_armed", 32'(armed), 32'd0);

        // 1010 overlap then non-overlap
        overlap_en = 1'b1;
        load(8'h0A, 4'd4, 1'b0);
        run("ov4", 16'b10_1010, 6, 16'b00_0101, 16'd4);
        chk("ov4_cnt", 32'(match_cnt), 32'd2);
        overlap_en = 1'b0;
        load(8'h0A, 4'd4, 1'b0);
        run("no4", 16'b10_1010, 6, 16'b00_0100, 16'd2);
        chk("no4_cnt", 32'(match_cnt), 32'd1);

        // len 1, upper pattern bits ignored, counter saturates at 3
        overlap_en = 1'b1;
        load(8'hF1, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bit_in(1'b1);
            chk($sformatf("sat_z%0d", i + 1), 32'(z), 32'd1);
            chk($sformatf("sat_cnt%0d", i + 1), 32'(match_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
            idle();
            chk($sformatf("idle_z%0d", i + 1), 32'(z), 32'd0);
            chk($sformatf("idle_fill%0d", i + 1), 32'(fill), 32'd1);
            chk($sformatf("idle_armed%0d", i + 1), 32'(armed), 32'd1);
        end

        // load while armed with a matching bit: bit discarded
        load(8'h01, 4'd0, 1'b1);
        chk("l0_z", 32'(z), 32'd0);
        chk("l0_fill", 32'(fill), 32'd0);
        chk("l0_cnt", 32'(match_cnt), 32'd0);
        chk("l0_armed", 32'(armed), 32'd0);
        bit_in(1'b1);
        chk("l0_hit_z", 32'(z), 32'd1);
        chk("l0_hit_armed", 32'(armed), 32'd1);

        // reset beats a matching bit and a load
        rst = 1'b0; x = 1'b1; x_valid = 1'b1; pat_load = 1'b1;
        cyc();
        rst = 1'b1; x_valid = 1'b0; pat_load = 1'b0;
        chk("mrst_z", 32'(z), 32'd0);
        chk("mrst_fill", 32'(fill), 32'd0);
        chk("mrst_cnt", 32'(match_cnt), 32'd0);
        chk("mrst_armed", 32'(armed), 32'd0);

        // pat_len 12 clamps to 8
        load(8'hA5, 4'd12, 1'b0);
        run("cl8", 16'b1010_0101, 8, 16'b0000_0001, 16'd8);
        chk("cl8_cnt", 32'(match_cnt), 32'd1);
        chk("cl8_armed", 32'(armed), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
